// File: rtl/noise_trigger_sequencer.sv
// Sound control register decode for the shell and explosion noise voices.
// Each voice gets minimum-hold and retrigger-gap timing; the shell is ducked while an explosion sounds.
module noise_trigger_sequencer #(
  parameter int unsigned MIN_HOLD   = 96,
  parameter int unsigned RETRIG_GAP = 24,
  parameter bit          DUCK_SHELL = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_3MHz_en,
  input  logic       clk_12KHz_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       sound_enable,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic [1:0] busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, SUSTAIN, GAP} state_e;

  // Image layout: [4]=sound_enable, [3]=shell_en, [2]=shell_ls, [1]=explo_en, [0]=explo_ls
  logic [4:0] img_q;
  logic       snd_q;
  logic       tick;
  logic [1:0] ch_en;
  logic [1:0] ch_ls;
  logic [1:0] ch_busy;
  logic       wr_data_unused;

  assign tick           = clk_3MHz_en & clk_12KHz_en;
  assign wr_data_unused = ^{wr_data[7:6], wr_data[4]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      img_q <= '0;
      snd_q <= 1'b0;
    end else begin
      if (wr_en) img_q <= {wr_data[5], wr_data[3:0]};
      if (clk_3MHz_en) snd_q <= img_q[4];
    end
  end

  // Channel 0 is the shell voice, channel 1 the explosion voice.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int unsigned EN_BIT = (g == 0) ? 3 : 1;
    localparam int unsigned LS_BIT = (g == 0) ? 2 : 0;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             ls_q;
    logic             pend_q;
    logic             img_en;
    logic             img_ls;
    logic             rise;

    assign img_en = img_q[EN_BIT];
    assign img_ls = img_q[LS_BIT];
    assign rise   = wr_en & wr_data[5] & wr_data[EN_BIT] & ~img_q[EN_BIT];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        ls_q    <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        if (clk_3MHz_en) begin
          if (!img_q[4]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ls_q    <= 1'b0;
            pend_q  <= 1'b0;
          end else begin
            case (state_q)
              IDLE: begin
                if (pend_q) begin
                  state_q <= ACTIVE;
                  cnt_q   <= CNT_W'(MIN_HOLD);
                  en_q    <= 1'b1;
                  ls_q    <= img_ls;
                  pend_q  <= 1'b0;
                end
              end
              ACTIVE: begin
                ls_q <= img_ls;
                // The tick that exhausts the hold time also performs the exit.
                if (tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                    if (img_en) begin
                      state_q <= SUSTAIN;
                      cnt_q   <= '0;
                    end else begin
                      state_q <= GAP;
                      cnt_q   <= CNT_W'(RETRIG_GAP);
                      en_q    <= 1'b0;
                      ls_q    <= 1'b0;
                    end
                  end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                  end
                end
              end
              SUSTAIN: begin
                if (!img_en) begin
                  state_q <= GAP;
                  cnt_q   <= CNT_W'(RETRIG_GAP);
                  en_q    <= 1'b0;
                  ls_q    <= 1'b0;
                end else begin
                  ls_q <= img_ls;
                end
              end
              GAP: begin
                if (tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                  end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                  end
                end
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        // A fresh edge outranks the clear from a start or a sound-off on the same clk.
        if (rise) pend_q <= 1'b1;
      end
    end

    assign ch_en[g]   = en_q;
    assign ch_ls[g]   = ls_q;
    assign ch_busy[g] = (state_q != IDLE);
  end

  assign sound_enable = snd_q;
  assign shell_en     = ch_en[0];
  assign shell_ls     = ch_ls[0] & ~(DUCK_SHELL & ch_en[1]);
  assign explo_en     = ch_en[1];
  assign explo_ls     = ch_ls[1];
  assign busy         = ch_busy;

endmodule

// File: tb/tb_noise_trigger_sequencer.sv
// Randomized scoreboard bench: a tick-counting voice model predicts outputs per 3 MHz enable,
// a separate monitor compares the DUT against them every clock.
module tb_noise_trigger_sequencer;
  localparam int unsigned MIN_HOLD   = 96;
  localparam int unsigned RETRIG_GAP = 24;
  localparam int unsigned N_CYCLES   = 40000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_3MHz_en;
  logic       clk_12KHz_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       sound_enable;
  logic       shell_en;
  logic       shell_ls;
  logic       explo_en;
  logic       explo_ls;
  logic [1:0] busy;

  always #5 clk = ~clk;

  noise_trigger_sequencer #(
    .MIN_HOLD  (MIN_HOLD),
    .RETRIG_GAP(RETRIG_GAP),
    .DUCK_SHELL(1'b1),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_3MHz_en (clk_3MHz_en),
    .clk_12KHz_en(clk_12KHz_en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .sound_enable(sound_enable),
    .shell_en    (shell_en),
    .shell_ls    (shell_ls),
    .explo_en    (explo_en),
    .explo_ls    (explo_ls),
    .busy        (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [6:0]  exp_q[$];

  // Reference model: each voice is "sounding" for a count of elapsed ticks,
  // then "resting" for a count of elapsed ticks, else silent.
  logic [7:0]  m_img;
  bit          m_snd;
  bit          m_on[2];
  bit          m_rest[2];
  bit          m_pend[2];
  bit          m_ls[2];
  int unsigned m_held[2];
  int unsigned m_rested[2];

  function automatic int unsigned en_bit(input int unsigned c);
    return (c == 0) ? 3 : 1;
  endfunction

  function automatic int unsigned ls_bit(input int unsigned c);
    return (c == 0) ? 2 : 0;
  endfunction

  function automatic void model_reset();
    m_img = '0;
    m_snd = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_on[c] = 0; m_rest[c] = 0; m_pend[c] = 0; m_ls[c] = 0;
      m_held[c] = 0; m_rested[c] = 0;
    end
  endfunction

  function automatic void start_rest(input int unsigned c);
    m_on[c]     = 0;
    m_ls[c]     = 0;
    m_rest[c]   = 1;
    m_rested[c] = 0;
  endfunction

  function automatic void model_step(input bit e3, input bit e12, input bit we, input logic [7:0] wd);
    bit tk;
    bit want;
    tk = e3 & e12;
    if (e3) begin
      m_snd = m_img[5];
      for (int unsigned c = 0; c < 2; c++) begin
        want = m_img[en_bit(c)];
        if (!m_img[5]) begin
          m_on[c] = 0; m_rest[c] = 0; m_pend[c] = 0; m_ls[c] = 0;
        end else if (m_on[c]) begin
          m_ls[c] = m_img[ls_bit(c)];
          if (m_held[c] < MIN_HOLD) begin
            if (tk) begin
              m_held[c]++;
              if (m_held[c] == MIN_HOLD && !want) start_rest(c);
            end
          end else if (!want) begin
            start_rest(c);
          end
        end else if (m_rest[c]) begin
          if (tk) begin
            m_rested[c]++;
            if (m_rested[c] == RETRIG_GAP) m_rest[c] = 0;
          end
        end else if (m_pend[c]) begin
          m_on[c]   = 1;
          m_held[c] = 0;
          m_ls[c]   = m_img[ls_bit(c)];
          m_pend[c] = 0;
        end
      end
    end
    if (we) begin
      for (int unsigned c = 0; c < 2; c++)
        if (wd[5] && wd[en_bit(c)] && !m_img[en_bit(c)]) m_pend[c] = 1;
      m_img = wd;
    end
  endfunction

  function automatic logic [6:0] model_out();
    logic [6:0] v;
    v[6]   = m_snd;
    v[5]   = m_on[0];
    v[4]   = m_on[0] & m_ls[0] & ~m_on[1];
    v[3]   = m_on[1];
    v[2]   = m_on[1] & m_ls[1];
    v[1:0] = {m_on[1] | m_rest[1], m_on[0] | m_rest[0]};
    return v;
  endfunction

  function automatic logic [6:0] dut_out();
    return {sound_enable, shell_en, shell_ls, explo_en, explo_ls, busy};
  endfunction

  // Monitor: DUT outputs move only on a 3 MHz enable; between enables they must hold.
  initial begin : monitor
    logic [6:0] cur;
    bit         upd;
    bit         live;
    cur = '0;
    forever begin
      @(posedge clk);
      upd  = clk_3MHz_en & reset_n;
      live = reset_n;
      #1;
      if (!live) begin
        cur = '0;
      end else begin
        if (upd) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_underflow at %0t: no expected entry for enable cycle", $time);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        checks++;
        if (dut_out() !== cur) begin
          errors++;
          $display("FAIL outputs at %0t: got snd/sh_en/sh_ls/ex_en/ex_ls/busy=%b expected %b",
                   $time, dut_out(), cur);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (dut_out() !== 7'd0) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected 0000000", name, $time, dut_out());
    end
  endtask

  initial begin : driver
    int unsigned div;
    reset_n      = 1'b0;
    clk_3MHz_en  = 1'b0;
    clk_12KHz_en = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 check_zero("reset_state");
    @(negedge clk) reset_n = 1'b1;

    for (int unsigned i = 0; i < N_CYCLES; i++) begin
      if (i == 12345 || i == 27000) begin
        @(posedge clk);
        #3 reset_n   = 1'b0;
        clk_3MHz_en  = 1'b0;
        wr_en        = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
      // Alternate busy write bursts with long quiet stretches so sustain is reached.
      div          = ((i / 5000) % 2 == 1) ? 1500 : 40;
      clk_3MHz_en  = ($urandom_range(0, 1) == 0);
      clk_12KHz_en = ($urandom_range(0, 3) == 0);
      wr_en        = ($urandom_range(0, div - 1) == 0);
      wr_data      = 8'($urandom_range(0, 255));
      wr_data[5]   = ($urandom_range(0, 9) != 0);
      model_step(clk_3MHz_en, clk_12KHz_en, wr_en, wr_data);
      if (clk_3MHz_en) exp_q.push_back(model_out());
    end

    @(negedge clk);
    clk_3MHz_en = 1'b0;
    wr_en       = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
